// File: rtl/btn_bounce_gen.sv
// Contact-bounce emulator: turns a clean level into a bouncy waveform with
// TOGGLES toggles at LFSR-driven pseudo-random gaps, then settles on the new level.
module btn_bounce_gen #(
   parameter int          TOGGLES  = 6,
   parameter int          GAP_MIN  = 2,
   parameter int          GAP_BITS = 3,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic press_i,
   output logic btn_o,
   output logic busy_o,
   output logic done_o
);

   localparam int               TOG_W    = (TOGGLES > 0) ? $clog2(TOGGLES + 1) : 1;
   localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(TOGGLES);
   // GAP_BITS = 0 yields an all-zero mask, i.e. a fixed gap of GAP_MIN.
   localparam logic [15:0]      GAP_MASK = 16'((32'd1 << GAP_BITS) - 32'd1);

   typedef enum logic {IDLE, BOUNCE} state_t;

   state_t           r_state;
   logic             r_tgt;
   logic             r_btn;
   logic             r_busy;
   logic             r_done;
   logic [7:0]       r_gap_cnt;
   logic [TOG_W-1:0] r_tog_cnt;
   logic [15:0]      r_lfsr;

   logic [15:0]      w_lfsr_next;
   logic [7:0]       w_gap;

   // Galois form, taps x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
   assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
   assign w_gap       = 8'(GAP_MIN) + 8'(r_lfsr & GAP_MASK);

   // NOTE: all state here is updated with <= so every branch sees pre-edge values
   // (the gap uses the LFSR value before this edge's advance).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: every register has a defined async reset value so the waveform is
      // reproducible from reset; there is no memory array to leave unreset.
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_tgt     <= 1'b0;
         r_btn     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_gap_cnt <= 8'd0;
         r_tog_cnt <= '0;
         r_lfsr    <= SEED;
      end else begin
         r_lfsr <= w_lfsr_next;
         r_done <= 1'b0;
         if (press_i != r_tgt) begin
            // New target (from IDLE or as a restart) overrides any event due now.
            r_tgt     <= press_i;
            r_tog_cnt <= '0;
            r_gap_cnt <= w_gap;
            r_busy    <= 1'b1;
            r_state   <= BOUNCE;
         end else if (r_state == BOUNCE) begin
            if (r_gap_cnt > 8'd1) begin
               r_gap_cnt <= r_gap_cnt - 8'd1;
            end else if (r_tog_cnt < TOG_LAST) begin
               r_btn     <= ~r_btn;
               r_tog_cnt <= r_tog_cnt + 1'b1;
               r_gap_cnt <= w_gap;
            end else begin
               r_btn   <= r_tgt;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
         end
      end
   end

   assign btn_o  = r_btn;
   assign busy_o = r_busy;
   assign done_o = r_done;

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Directed bench for btn_bounce_gen: fixed-gap, restart, no-bounce, random-gap
// and mid-sequence reset reproducibility, on three differently sized instances.
module tb_btn_bounce_gen;

   logic clk;
   logic rst_n;
   logic press_fix, press_nb, press_rnd;
   logic btn_fix, busy_fix, done_fix;
   logic btn_nb, busy_nb, done_nb;
   logic btn_rnd, busy_rnd, done_rnd;

   int n_cmp = 0;
   int n_err = 0;
   int ev [2][8];
   int nev [2];

   btn_bounce_gen #(.TOGGLES(4), .GAP_MIN(3), .GAP_BITS(0)) u_fix (
      .clk_i(clk), .rst_ni(rst_n), .press_i(press_fix),
      .btn_o(btn_fix), .busy_o(busy_fix), .done_o(done_fix));

   btn_bounce_gen #(.TOGGLES(0), .GAP_MIN(5), .GAP_BITS(0)) u_nb (
      .clk_i(clk), .rst_ni(rst_n), .press_i(press_nb),
      .btn_o(btn_nb), .busy_o(busy_nb), .done_o(done_nb));

   btn_bounce_gen u_rnd (
      .clk_i(clk), .rst_ni(rst_n), .press_i(press_rnd),
      .btn_o(btn_rnd), .busy_o(busy_rnd), .done_o(done_rnd));

   initial begin
      clk = 1'b0;
      #20;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Async reset between edges, then identical stimulus relative to release.
   task automatic record(input int run);
      logic prev;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_btn", btn_rnd, 1'b0);
      check("mid_rst_busy", busy_rnd, 1'b0);
      check("mid_rst_done", done_rnd, 1'b0);
      press_rnd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      press_rnd = 1'b1;
      nev[run] = 0;
      prev = btn_rnd;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (btn_rnd != prev) begin
            if (nev[run] < 8) ev[run][nev[run]] = c;
            nev[run]++;
            prev = btn_rnd;
         end
      end
   endtask

   initial begin
      bit any_out;
      int ndone;
      int last, nchg;
      logic prev;

      rst_n     = 1'b0;
      press_fix = 1'b1;
      press_nb  = 1'b1;
      press_rnd = 1'b1;
      #5;
      check("rst_btn", btn_rnd, 1'b0);
      check("rst_busy", busy_rnd, 1'b0);
      check("rst_done", done_rnd, 1'b0);
      check("rst_fix_btn", btn_fix, 1'b0);
      #3;
      press_fix = 1'b0;
      press_nb  = 1'b0;
      press_rnd = 1'b0;
      #4 rst_n = 1'b1;
      any_out = 1'b0;
      repeat (50) begin
         tick();
         any_out |= btn_fix | busy_fix | done_fix | btn_nb | busy_nb | done_nb
                  | btn_rnd | busy_rnd | done_rnd;
      end
      check("idle_quiet", any_out, 1'b0);

      // Fixed gap: events at edges 3,6,9,12 (toggles) and 15 (settle).
      press_fix = 1'b1;
      for (int e = 0; e < 16; e++) begin
         tick();
         check("fix_btn", btn_fix, ((e >= 3 && e < 6) || (e >= 9 && e < 12) || e >= 15));
         check("fix_busy", busy_fix, (e < 15));
         check("fix_done", done_fix, (e == 15));
      end
      press_fix = 1'b0;
      repeat (40) tick();
      check("fix_rel_btn", btn_fix, 1'b0);

      // Restart: press drops, sampled at edge 7; settle on 0 at edge 22.
      press_fix = 1'b1;
      ndone = 0;
      for (int e = 0; e < 24; e++) begin
         tick();
         check("rs_btn", btn_fix, ((e >= 3 && e < 6) || (e >= 10 && e < 13) || (e >= 16 && e < 19)));
         check("rs_busy", busy_fix, (e < 22));
         if (done_fix) ndone++;
         if (e == 6) press_fix = 1'b0;
      end
      check("rs_done_cnt", ndone, 1);

      // No bounce: single clean edge 5 cycles after sampling, both directions.
      press_nb = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         check("nb_rise_btn", btn_nb, (e >= 5));
         check("nb_rise_done", done_nb, (e == 5));
      end
      press_nb = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         check("nb_fall_btn", btn_nb, (e < 5));
         check("nb_fall_done", done_nb, (e == 5));
      end

      // Random gaps with defaults: spacing in [2,9], 7 events, settle matches press.
      for (int p = 0; p < 20; p++) begin
         press_rnd = ~press_rnd;
         last  = 0;
         nchg  = 0;
         ndone = 0;
         prev  = btn_rnd;
         for (int c = 0; c < 200; c++) begin
            tick();
            if (c == 0) check("rnd_busy", busy_rnd, 1'b1);
            if (btn_rnd != prev) begin
               check("rnd_gap_range", ((c - last) >= 2 && (c - last) <= 9), 1'b1);
               last = c;
               nchg++;
               prev = btn_rnd;
            end
            if (done_rnd) begin
               ndone++;
               check("rnd_settle", btn_rnd, press_rnd);
            end
         end
         check("rnd_events", nchg, 7);
         check("rnd_done_cnt", ndone, 1);
      end

      // Mid-sequence reset, then two identical runs must produce identical gaps.
      press_rnd = ~press_rnd;
      repeat (4) tick();
      check("pre_rst_busy", busy_rnd, 1'b1);
      record(0);
      record(1);
      check("repro_cnt0", nev[0], 7);
      check("repro_cnt1", nev[1], 7);
      for (int i = 0; i < 7; i++) check("repro_evt", ev[1][i], ev[0][i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
